// File: rtl/shot_detect.sv
// shot_detect -- flick-magnitude shot detector.
//
// A sample is taken on every y_valid cycle. The X component is the most recent
// x_flick (or the coincident one when x_valid and y_valid share a cycle). The
// combined magnitude drives a four-state FSM: IDLE -> ARMED -> TRACK -> COOLDOWN.
// A shot starts when the magnitude reaches THRESH and ends when it falls below
// RELEASE. Shots with at least MIN_SAMPLES tracked samples report the X/Y pair
// taken at the first strict peak. After every shot the FSM ignores HOLDOFF
// samples before it re-arms.
//
// Optional feature: define SHOT_TIMEOUT_EN to abort any shot still tracking
// after TIMEOUT_SAMPLES samples. Without it, shot_abort is constant 0.
//
// Ports
//   clk, rst_n          4 MHz accelerometer clock, async active-low reset
//   x_valid, x_flick    X flick update strobe / 16-bit unsigned magnitude
//   y_valid, y_flick    Y flick update strobe (sample strobe) / magnitude
//   arm                 level enable for detection
//   shot_valid          1-cycle pulse per accepted shot
//   shot_x, shot_y      components at the shot peak, held until next shot
//   shot_count          accepted shots, wraps 255 -> 0
//   busy                high in TRACK or COOLDOWN
//   shot_abort          1-cycle timeout pulse (SHOT_TIMEOUT_EN only)
module shot_detect #(
  parameter logic [16:0] THRESH          = 17'd400,
  parameter logic [16:0] RELEASE         = 17'd150,
  parameter int          MIN_SAMPLES     = 4,
  parameter int          HOLDOFF         = 16,
  parameter int          TIMEOUT_SAMPLES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_valid,
  input  logic        y_valid,
  input  logic [15:0] x_flick,
  input  logic [15:0] y_flick,
  input  logic        arm,
  output logic        shot_valid,
  output logic [15:0] shot_x,
  output logic [15:0] shot_y,
  output logic [7:0]  shot_count,
  output logic        busy,
  output logic        shot_abort
);

`ifdef SHOT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, COOLDOWN} state_t;

  state_t      state;
  logic [15:0] x_hold;
  logic [15:0] x_cur;
  logic [16:0] mag;
  logic [16:0] peak;
  logic [15:0] pk_x, pk_y;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic [15:0] cd_cnt;
  logic        cd_done;
  logic        tmo_hit;

  // A coincident x update is used by the same sample.
  assign x_cur   = x_valid ? x_flick : x_hold;
  assign mag     = {1'b0, x_cur} + {1'b0, y_flick};
  assign cnt_nx  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign cd_done = (int'(cd_cnt) + 1) >= HOLDOFF;
  // With the timeout disabled this is constant 0 and the abort path vanishes.
  assign tmo_hit = TMO_EN && (int'(cnt_nx) >= TIMEOUT_SAMPLES);
  assign busy    = (state == TRACK) || (state == COOLDOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_hold     <= '0;
      peak       <= '0;
      pk_x       <= '0;
      pk_y       <= '0;
      cnt        <= '0;
      cd_cnt     <= '0;
      shot_valid <= 1'b0;
      shot_abort <= 1'b0;
      shot_x     <= '0;
      shot_y     <= '0;
      shot_count <= '0;
    end else begin
      shot_valid <= 1'b0;
      shot_abort <= 1'b0;
      if (x_valid) x_hold <= x_flick;
      case (state)
        IDLE: if (arm) state <= ARMED;
        ARMED: begin
          if (!arm) state <= IDLE;
          else if (y_valid && mag >= THRESH) begin
            state <= TRACK;
            peak  <= mag;
            pk_x  <= x_cur;
            pk_y  <= y_flick;
            cnt   <= 8'd1;
          end
        end
        TRACK: if (y_valid) begin
          if (mag < RELEASE) begin
            state  <= COOLDOWN;
            cd_cnt <= '0;
            if (int'(cnt) >= MIN_SAMPLES) begin
              shot_x     <= pk_x;
              shot_y     <= pk_y;
              shot_valid <= 1'b1;
              shot_count <= shot_count + 8'd1;
            end
          end else begin
            cnt <= cnt_nx;
            // Strict compare: ties keep the earlier peak.
            if (mag > peak) begin
              peak <= mag;
              pk_x <= x_cur;
              pk_y <= y_flick;
            end
            if (tmo_hit) begin
              state      <= COOLDOWN;
              cd_cnt     <= '0;
              shot_abort <= 1'b1;
            end
          end
        end
        COOLDOWN: if (y_valid) begin
          if (cd_done) state <= arm ? ARMED : IDLE;
          else         cd_cnt <= cd_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_detect.sv
module tb_shot_detect;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0, y_valid = 1'b0, arm = 1'b0;
  logic [15:0] x_flick = '0, y_flick = '0;
  logic        shot_valid, busy, shot_abort;
  logic [15:0] shot_x, shot_y;
  logic [7:0]  shot_count;

  shot_detect #(.TIMEOUT_SAMPLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .y_valid(y_valid),
    .x_flick(x_flick), .y_flick(y_flick), .arm(arm),
    .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
    .shot_count(shot_count), .busy(busy), .shot_abort(shot_abort)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: a shot is the list of its tracked samples; the reported
  // pair is the first sample of maximal magnitude in that list.
  int ph = 0;             // 0 idle, 1 armed, 2 tracking, 3 holdoff
  int m_xh = 0, m_cnt = 0, m_sx = 0, m_sy = 0, m_cd = 0;
  bit m_sv = 0, m_ab = 0;
  int qx[$], qy[$];

  always @(posedge clk or negedge rst_n) begin
    int mx, mag;
    if (!rst_n) begin
      ph = 0; m_xh = 0; m_cnt = 0; m_sx = 0; m_sy = 0; m_cd = 0;
      m_sv = 0; m_ab = 0; qx.delete(); qy.delete();
    end else begin
      m_sv = 0; m_ab = 0;
      if (x_valid) m_xh = x_flick;
      mx  = m_xh;
      mag = mx + int'(y_flick);
      case (ph)
        0: if (arm) ph = 1;
        1: if (!arm) ph = 0;
           else if (y_valid && mag >= 400) begin
             qx.delete(); qy.delete();
             qx.push_back(mx); qy.push_back(int'(y_flick));
             ph = 2;
           end
        2: if (y_valid) begin
             if (mag < 150) begin
               if (qx.size() >= 4) begin
                 int best;
                 best = 0;
                 for (int i = 1; i < qx.size(); i++)
                   if (qx[i] + qy[i] > qx[best] + qy[best]) best = i;
                 m_sx = qx[best]; m_sy = qy[best];
                 m_cnt = (m_cnt + 1) % 256;
                 m_sv = 1;
               end
               ph = 3; m_cd = 16;
             end else begin
               qx.push_back(mx); qy.push_back(int'(y_flick));
`ifdef SHOT_TIMEOUT_EN
               if (qx.size() >= TMO) begin ph = 3; m_cd = 16; m_ab = 1; end
`endif
             end
           end
        3: if (y_valid) begin
             m_cd--;
             if (m_cd == 0) ph = arm ? 1 : 0;
           end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("shot_valid", shot_valid, m_sv);
    chk("shot_abort", shot_abort, m_ab);
    chk("shot_x", shot_x, m_sx);
    chk("shot_y", shot_y, m_sy);
    chk("shot_count", shot_count, m_cnt);
    chk("busy", busy, (ph == 2 || ph == 3));
  end

  task automatic samp(input int x, input int y);
    @(negedge clk);
    x_valid = 1; y_valid = 1; x_flick = 16'(x); y_flick = 16'(y);
    @(negedge clk);
    x_valid = 0; y_valid = 0;
  endtask

  task automatic xonly(input int x);
    @(negedge clk); x_valid = 1; x_flick = 16'(x);
    @(negedge clk); x_valid = 0;
  endtask

  task automatic yonly(input int y);
    @(negedge clk); y_valid = 1; y_flick = 16'(y);
    @(negedge clk); y_valid = 0;
  endtask

  task automatic cool(input int n);
    repeat (n) samp(0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", shot_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", shot_x, 0);
    rst_n = 1; arm = 1;
    @(negedge clk);

    // Basic shot: peak 900 as 450/450
    samp(50, 50); samp(250, 250); samp(350, 350); samp(450, 450); samp(300, 300); samp(50, 50);
    chk("s1_valid", shot_valid, 1); chk("s1_x", shot_x, 450);
    chk("s1_y", shot_y, 450); chk("s1_count", shot_count, 1);
    cool(15); chk("s1_busy15", busy, 1);
    cool(1);  chk("s1_busy16", busy, 0);

    // Too short: discarded, still cools down
    samp(250, 250); samp(300, 300); samp(50, 50);
    chk("s2_valid", shot_valid, 0); chk("s2_busy", busy, 1);
    chk("s2_count", shot_count, 1); chk("s2_x_held", shot_x, 450);
    cool(15); chk("s2_busy15", busy, 1);
    cool(1);  chk("s2_busy16", busy, 0);

    // Tied peak 800, first one (via held x) wins
    xonly(500); yonly(300);
    samp(300, 500); samp(300, 300); samp(200, 200); samp(50, 50);
    chk("s3_x", shot_x, 500); chk("s3_y", shot_y, 300); chk("s3_count", shot_count, 2);
    cool(16);

    // Disarmed: no detection; arm dropped mid-track still reports
    arm = 0;
    samp(500, 500); samp(500, 500);
    chk("s4_idle_busy", busy, 0);
    arm = 1; @(negedge clk);
    samp(460, 440); samp(450, 450);
    arm = 0;
    samp(400, 500); samp(300, 300); samp(10, 10);
    chk("s4_valid", shot_valid, 1); chk("s4_x", shot_x, 460);
    chk("s4_y", shot_y, 440); chk("s4_count", shot_count, 3);
    cool(16);
    samp(500, 500);
    chk("s4_stay_idle", busy, 0);

    // Reset in the middle of a track
    arm = 1; @(negedge clk);
    repeat (10) samp(450, 450);
    #2 rst_n = 0;
    #1;
    chk("r_count", shot_count, 0); chk("r_x", shot_x, 0); chk("r_y", shot_y, 0);
    chk("r_busy", busy, 0); chk("r_valid", shot_valid, 0);
    @(negedge clk); rst_n = 1;
    samp(50, 50);
    chk("r_no_shot", shot_valid, 0);

    // 256 accepted shots wrap the counter
    for (int k = 0; k < 256; k++) begin
      repeat (4) samp(300, 300);
      samp(0, 0);
      if (k == 0) chk("w_first", shot_count, 1);
      cool(16);
    end
    chk("w_wrap", shot_count, 0);

    // Long track: timeout aborts it, otherwise released normally
    for (int i = 0; i < 12; i++) begin
      samp(450, 450);
`ifdef SHOT_TIMEOUT_EN
      if (i == TMO - 1) chk("t_abort", shot_abort, 1);
`endif
    end
    samp(50, 50);
`ifdef SHOT_TIMEOUT_EN
    chk("t_valid", shot_valid, 0); chk("t_count", shot_count, 0);
`else
    chk("t_valid", shot_valid, 1); chk("t_count", shot_count, 1);
`endif
    cool(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shot_detect.md
SHOT_DETECT -- requirements
Module: shot_detect

Interface
REQ-001 The block SHALL have parameter THRESH, default 17'd400, meaning the combined flick magnitude that starts a shot.
REQ-002 The block SHALL have parameter RELEASE, default 17'd150, meaning the magnitude below which a tracked shot ends.
REQ-003 The block SHALL have parameter MIN_SAMPLES, default 4, meaning the minimum number of TRACK samples for a valid shot.
REQ-004 The block SHALL have parameter HOLDOFF, default 16, meaning the number of cooldown samples after a shot ends.
REQ-005 The block SHALL have parameter TIMEOUT_SAMPLES, default 200, meaning the TRACK sample limit (used only under SHOT_TIMEOUT_EN).
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, the 4 MHz accelerometer domain.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have ports x_valid and y_valid, input, 1 bit each: flick-filter update strobes.
REQ-009 The block SHALL have ports x_flick and y_flick, input, 16 bits each: unsigned filtered flick magnitudes.
REQ-010 The block SHALL have port arm, input, 1 bit: level enable for shot detection.
REQ-011 The block SHALL have port shot_valid, output, 1 bit: one-cycle pulse per accepted shot.
REQ-012 The block SHALL have ports shot_x and shot_y, output, 16 bits each: X and Y components at the shot peak.
REQ-013 The block SHALL have port shot_count, output, 8 bits: count of accepted shots.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the state is TRACK or COOLDOWN.
REQ-015 The block SHALL have port shot_abort, output, 1 bit: one-cycle timeout pulse, held 0 when SHOT_TIMEOUT_EN is undefined.

Function
REQ-016 x_flick SHALL be latched into x_hold on x_valid, and every y_valid cycle SHALL constitute one sample; if x_valid and y_valid coincide, the sample SHALL use the new x_flick.
REQ-017 mag SHALL equal zero-extended x plus zero-extended y, 17 bits, which cannot overflow.
REQ-018 The FSM SHALL have exactly four states, IDLE, ARMED, TRACK and COOLDOWN, and reset SHALL enter IDLE.
REQ-019 IDLE SHALL go to ARMED when arm=1, and ARMED SHALL go to IDLE when arm=0, each on the next clock.
REQ-020 ARMED SHALL go to TRACK on a sample with mag>=THRESH, loading peak, shot_x and shot_y candidates from that sample and setting the sample counter to 1.
REQ-021 On each TRACK sample with mag>=RELEASE, the counter SHALL increment (saturating at 255), and peak and its x/y components SHALL update only if mag>peak strictly, so ties keep the earlier peak.
REQ-022 A TRACK sample with mag<RELEASE SHALL end the shot and go to COOLDOWN; if counter>=MIN_SAMPLES, the block SHALL register the peak components to shot_x/shot_y, pulse shot_valid in the next cycle, and increment shot_count, which wraps 255->0.
REQ-023 A shot ending with counter<MIN_SAMPLES SHALL be discarded (no pulse, shot_x/shot_y unchanged) and still go to COOLDOWN.
REQ-024 COOLDOWN SHALL count HOLDOFF samples, then go to ARMED if arm=1, else IDLE.
REQ-025 arm deasserting in TRACK or COOLDOWN SHALL NOT abort: the shot completes normally.
REQ-026 shot_x and shot_y SHALL hold their values until the next shot_valid.
REQ-027 Cycles without y_valid SHALL NOT change the state, counters or peak.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously clear the state to IDLE and set all outputs, x_hold, peak, and counters to 0; the release SHALL be synchronous to clk.
REQ-029 When reset asserts mid-TRACK, the block SHALL discard the pending shot with no shot_valid after release.

Configuration
REQ-030 With SHOT_TIMEOUT_EN defined, the TRACK counter reaching TIMEOUT_SAMPLES with no release SHALL go to COOLDOWN, pulse shot_abort for one cycle, and produce no shot_valid.
REQ-031 With SHOT_TIMEOUT_EN undefined, TRACK SHALL persist until release, and shot_abort SHALL be constant 0.

Verification
REQ-032 Scenario: arm=1, samples mag 100,500,700,900,600,100 (x=y=mag/2) -> one shot_valid the cycle after the 100 sample, shot_x=shot_y=450, shot_count=1.
REQ-033 Scenario: arm=1, samples 500,600,100 -> no shot_valid (count 2<4), COOLDOWN entered, busy=1 for 16 samples.
REQ-034 Scenario: peak 800 seen twice, first x=500,y=300 then x=300,y=500 -> shot_x=500, shot_y=300.
REQ-035 Scenario: arm=0 with samples of 1000 -> stays IDLE, no shot; arm dropped mid-TRACK -> shot still reported, then IDLE after cooldown.
REQ-036 Scenario: rst_n low mid-TRACK after 10 samples of 900 -> all outputs 0, no shot_valid afterwards, 256 accepted shots -> shot_count=0.
REQ-037 Scenario: SHOT_TIMEOUT_EN, TIMEOUT_SAMPLES=8, 12 samples of 900 -> shot_abort pulse at sample 8, no shot_valid; without the macro -> shot_valid on release.
